// File: rtl/ads54j60_deframer.sv
`default_nettype none
// ============================================================================
//  Module   : ads54j60_deframer
//  Purpose  : Unpacks the 128-bit JESD204 RX stream (LMFS=4211, F=1, K=8)
//             into two 16-bit ADC channels, 4 samples/clock, with multiframe
//             alignment checking and a lock state machine gating validity.
//  Option   : define ADS54J60_DEFRAMER_ERRCNT_EN to build the error counter.
//  Revision : 1.0 - initial release
// ============================================================================
module ads54j60_deframer #(
    parameter int LOCK_MF = 4,
    parameter int ERR_W   = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             rx_aresetn,
    input  logic [127:0]     rx_tdata,
    input  logic             rx_tvalid,
    input  logic             rx_sync,
    input  logic [3:0]       rx_start_of_multiframe,
    input  logic [15:0]      rx_frame_error,
    input  logic             clear_err,
    output logic [63:0]      adc_a,
    output logic [63:0]      adc_b,
    output logic             adc_valid,
    output logic [1:0]       state,
    output logic [ERR_W-1:0] err_cnt
);

    localparam logic [1:0] c_st_idle    = 2'd0;
    localparam logic [1:0] c_st_acq     = 2'd1;
    localparam logic [1:0] c_st_locked  = 2'd2;
    localparam logic [3:0] c_somf_first = 4'b0001;
    localparam logic [3:0] c_lock_mf    = 4'(LOCK_MF);

    logic [127:0] r_s1_data;
    logic         r_s1_valid;
    logic [3:0]   r_s1_somf;
    logic         r_s1_ferr;

    logic [1:0]   r_state;
    logic [3:0]   r_good_mf;
    logic         r_phase;

    logic [63:0]  r_adc_a;
    logic [63:0]  r_adc_b;
    logic         r_adc_valid;

    logic         w_link_ok;
    logic         w_drop;
    logic         w_somf_first;
    logic         w_misalign;
    logic         w_err_event;
    logic [3:0]   w_good_inc;
    logic [63:0]  w_unp_a;
    logic [63:0]  w_unp_b;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_s1_data  <= '0;
            r_s1_valid <= 1'b0;
            r_s1_somf  <= '0;
            r_s1_ferr  <= 1'b0;
        end else begin
            r_s1_data  <= rx_tdata;
            r_s1_valid <= rx_tvalid;
            r_s1_somf  <= rx_start_of_multiframe;
            r_s1_ferr  <= |rx_frame_error;
        end
    end

    assign w_link_ok    = rx_aresetn & rx_sync;
    // A gap in the stream only breaks lock once LOCKED; earlier states just wait.
    assign w_drop       = ~w_link_ok | (~r_s1_valid & (r_state == c_st_locked));
    assign w_somf_first = (r_s1_somf == c_somf_first);
    assign w_good_inc   = r_good_mf + 4'd1;

    // A start seen on an even phase means the previous multiframe was short.
    assign w_misalign = ((r_s1_somf != 4'b0000) & ~w_somf_first)
                      | (w_somf_first & ~r_phase &
                         (((r_state == c_st_acq) & (r_good_mf != 4'd0)) |
                          (r_state == c_st_locked)));
    assign w_err_event = r_s1_valid & (r_s1_ferr | w_misalign);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state   <= c_st_idle;
            r_good_mf <= '0;
            r_phase   <= 1'b0;
        end else if (w_drop) begin
            r_state   <= c_st_idle;
            r_good_mf <= '0;
            r_phase   <= 1'b0;
        end else if (r_s1_valid) begin
            r_phase <= w_somf_first ? 1'b0 : ~r_phase;
            case (r_state)
                c_st_idle: begin
                    if (w_somf_first) begin
                        r_good_mf <= 4'd1;
                        r_state   <= (c_lock_mf <= 4'd1) ? c_st_locked : c_st_acq;
                    end
                end
                c_st_acq: begin
                    if (w_err_event) begin
                        r_good_mf <= '0;
                    end else if (w_somf_first) begin
                        r_good_mf <= w_good_inc;
                        if (w_good_inc >= c_lock_mf) begin
                            r_state <= c_st_locked;
                        end
                    end
                end
                c_st_locked: begin
                    if (w_err_event) begin
                        r_state   <= c_st_acq;
                        r_good_mf <= '0;
                    end
                end
                default: begin
                    r_state   <= c_st_idle;
                    r_good_mf <= '0;
                end
            endcase
        end
    end

    // Lane 0/2 carry the MSB octet of each A/B sample.
    for (genvar k = 0; k < 4; k++) begin : g_sample
        assign w_unp_a[16*k +: 16] = {r_s1_data[8*k +: 8],      r_s1_data[32 + 8*k +: 8]};
        assign w_unp_b[16*k +: 16] = {r_s1_data[64 + 8*k +: 8], r_s1_data[96 + 8*k +: 8]};
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_adc_a     <= '0;
            r_adc_b     <= '0;
            r_adc_valid <= 1'b0;
        end else begin
            r_adc_a     <= w_unp_a;
            r_adc_b     <= w_unp_b;
            r_adc_valid <= r_s1_valid & (r_state == c_st_locked) & ~w_err_event;
        end
    end

`ifdef ADS54J60_DEFRAMER_ERRCNT_EN
    logic [ERR_W-1:0] r_err_cnt;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_err_cnt <= '0;
        end else if (clear_err) begin
            r_err_cnt <= '0;
        end else if (w_err_event && (r_state != c_st_idle) && (r_err_cnt != {ERR_W{1'b1}})) begin
            r_err_cnt <= r_err_cnt + ERR_W'(1);
        end
    end

    assign err_cnt = r_err_cnt;
`else
    logic w_unused_clear_err;
    assign w_unused_clear_err = clear_err;
    assign err_cnt            = '0;
`endif

    assign adc_a     = r_adc_a;
    assign adc_b     = r_adc_b;
    assign adc_valid = r_adc_valid;
    assign state     = r_state;

endmodule
`default_nettype wire

// File: tb/tb_ads54j60_deframer.sv
`default_nettype none
// ============================================================================
//  Module   : tb_ads54j60_deframer
//  Purpose  : Self-checking bench for ads54j60_deframer against a beat-level
//             behavioural model of the lock/alignment rules.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_ads54j60_deframer;

    localparam int LOCK_MF = 4;
    localparam int ERR_W   = 4;
`ifdef ADS54J60_DEFRAMER_ERRCNT_EN
    localparam bit ERRCNT_ON = 1'b1;
`else
    localparam bit ERRCNT_ON = 1'b0;
`endif

    logic             clk = 1'b0;
    logic             rst;
    logic             rx_aresetn;
    logic [127:0]     rx_tdata;
    logic             rx_tvalid;
    logic             rx_sync;
    logic [3:0]       rx_start_of_multiframe;
    logic [15:0]      rx_frame_error;
    logic             clear_err;
    logic [63:0]      adc_a;
    logic [63:0]      adc_b;
    logic             adc_valid;
    logic [1:0]       state;
    logic [ERR_W-1:0] err_cnt;

    ads54j60_deframer #(.LOCK_MF(LOCK_MF), .ERR_W(ERR_W)) dut (
        .clk                    (clk),
        .rst                    (rst),
        .rx_aresetn             (rx_aresetn),
        .rx_tdata               (rx_tdata),
        .rx_tvalid              (rx_tvalid),
        .rx_sync                (rx_sync),
        .rx_start_of_multiframe (rx_start_of_multiframe),
        .rx_frame_error         (rx_frame_error),
        .clear_err              (clear_err),
        .adc_a                  (adc_a),
        .adc_b                  (adc_b),
        .adc_valid              (adc_valid),
        .state                  (state),
        .err_cnt                (err_cnt)
    );

    always #5 clk = ~clk;

    int n_vec = 0;
    int n_bad = 0;
    int b_ph  = 0;

    // Reference model: beat held in the input register plus lock bookkeeping.
    int           m_state, m_good, m_phase, m_cnt;
    logic [127:0] m_d;
    bit           m_v, m_ferr;
    logic [3:0]   m_somf;
    logic [63:0]  e_a, e_b;
    bit           e_v;
    logic [1:0]   e_state;
    logic [ERR_W-1:0] e_cnt;

    task automatic model_reset();
        m_state = 0; m_good = 0; m_phase = 0; m_cnt = 0;
        m_d = '0; m_v = 0; m_ferr = 0; m_somf = '0;
        e_a = '0; e_b = '0; e_v = 0; e_state = 2'd0; e_cnt = '0;
    endtask

    task automatic model_edge();
        bit link, first, mis, ev;
        logic [127:0] sh;
        link  = rx_aresetn && rx_sync;
        first = (m_somf == 4'b0001);
        mis   = 0;
        if (m_somf != 4'b0000 && !first) mis = 1;
        if (first && m_phase == 0 && ((m_state == 1 && m_good > 0) || m_state == 2)) mis = 1;
        ev = m_v && (m_ferr || mis);
        for (int k = 0; k < 4; k++) begin
            sh = m_d >> (8 * k);
            e_a[16*k +: 16] = 16'((sh & 128'hFF) * 256 + ((sh >> 32) & 128'hFF));
            e_b[16*k +: 16] = 16'(((sh >> 64) & 128'hFF) * 256 + ((sh >> 96) & 128'hFF));
        end
        e_v = m_v && (m_state == 2) && !ev;
        if (clear_err) m_cnt = 0;
        else if (ev && m_state != 0 && m_cnt < (1 << ERR_W) - 1) m_cnt = m_cnt + 1;
        if (!link || (!m_v && m_state == 2)) begin
            m_state = 0; m_good = 0; m_phase = 0;
        end else if (m_v) begin
            m_phase = first ? 0 : 1 - m_phase;
            if (m_state == 0) begin
                if (first) begin m_good = 1; m_state = (LOCK_MF <= 1) ? 2 : 1; end
            end else if (m_state == 1) begin
                if (ev) m_good = 0;
                else if (first) begin
                    m_good = m_good + 1;
                    if (m_good >= LOCK_MF) m_state = 2;
                end
            end else if (ev) begin
                m_state = 1; m_good = 0;
            end
        end
        e_state = 2'(m_state);
        e_cnt   = ERRCNT_ON ? ERR_W'(m_cnt) : '0;
        m_d = rx_tdata; m_v = rx_tvalid; m_somf = rx_start_of_multiframe;
        m_ferr = |rx_frame_error;
    endtask

    task automatic step();
        model_edge();
        @(posedge clk);
        #1;
    endtask

    // Drives one aligned beat: SOMF on even bench phase.
    task automatic beat(input logic [127:0] d, input logic [15:0] fe);
        rx_tdata = d;
        rx_tvalid = 1'b1;
        rx_start_of_multiframe = (b_ph == 0) ? 4'b0001 : 4'b0000;
        rx_frame_error = fe;
        b_ph = 1 - b_ph;
        step();
    endtask

    function automatic logic [127:0] rnd128();
        return {$urandom, $urandom, $urandom, $urandom};
    endfunction

    task automatic test_reset();
        rst = 1'b1; rx_aresetn = 1'b0; rx_tdata = '0; rx_tvalid = 1'b0; rx_sync = 1'b0;
        rx_start_of_multiframe = '0; rx_frame_error = '0; clear_err = 1'b0;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        n_vec++;
        if ({adc_a, adc_b, adc_valid, state, err_cnt} !== '0) begin
            n_bad++;
            $display("FAIL reset: got a=%h b=%h v=%b st=%0d cnt=%0d exp all zero", adc_a, adc_b, adc_valid, state, err_cnt);
        end
        rst = 1'b0;
        rx_aresetn = 1'b1; rx_sync = 1'b1;
    endtask

    task automatic test_clean_lock();
        b_ph = 0;
        for (int i = 0; i < 12; i++) begin
            beat({{4{8'h78}}, {4{8'h56}}, {4{8'h34}}, {4{8'h12}}}, 16'h0000);
            n_vec++;
            if ({adc_a, adc_b, adc_valid, state, err_cnt} !== {e_a, e_b, e_v, e_state, e_cnt}) begin
                n_bad++;
                $display("FAIL clean_lock beat %0d: got a=%h b=%h v=%b st=%0d cnt=%0d exp a=%h b=%h v=%b st=%0d cnt=%0d",
                         i, adc_a, adc_b, adc_valid, state, err_cnt, e_a, e_b, e_v, e_state, e_cnt);
            end
        end
        n_vec++;
        if (state !== 2'd2 || adc_a[15:0] !== 16'h1234 || adc_b[15:0] !== 16'h5678 || adc_valid !== 1'b1 || err_cnt !== '0) begin
            n_bad++;
            $display("FAIL clean_lock final: got st=%0d a0=%h b0=%h v=%b cnt=%0d exp st=2 a0=1234 b0=5678 v=1 cnt=0",
                     state, adc_a[15:0], adc_b[15:0], adc_valid, err_cnt);
        end
    endtask

    task automatic test_frame_error();
        logic [ERR_W-1:0] c0;
        c0 = err_cnt;
        if (b_ph == 0) beat(rnd128(), 16'h0000);
        beat(rnd128(), 16'h0004);
        beat(rnd128(), 16'h0000);
        n_vec++;
        if (adc_valid !== 1'b0 || state !== 2'd1 || err_cnt !== (ERRCNT_ON ? c0 + ERR_W'(1) : '0)) begin
            n_bad++;
            $display("FAIL frame_error: got v=%b st=%0d cnt=%0d exp v=0 st=1 cnt=%0d",
                     adc_valid, state, err_cnt, ERRCNT_ON ? c0 + ERR_W'(1) : '0);
        end
        for (int i = 0; i < 10; i++) begin
            beat(rnd128(), 16'h0000);
            n_vec++;
            if ({adc_a, adc_b, adc_valid, state, err_cnt} !== {e_a, e_b, e_v, e_state, e_cnt}) begin
                n_bad++;
                $display("FAIL frame_error relock %0d: got a=%h b=%h v=%b st=%0d cnt=%0d exp a=%h b=%h v=%b st=%0d cnt=%0d",
                         i, adc_a, adc_b, adc_valid, state, err_cnt, e_a, e_b, e_v, e_state, e_cnt);
            end
        end
        n_vec++;
        if (state !== 2'd2) begin
            n_bad++;
            $display("FAIL frame_error relock state: got %0d exp 2", state);
        end
    endtask

    task automatic test_misalign();
        logic [ERR_W-1:0] c0;
        c0 = err_cnt;
        if (b_ph == 1) beat(rnd128(), 16'h0000);
        beat(rnd128(), 16'h0000);
        b_ph = 0;
        beat(rnd128(), 16'h0000);
        beat(rnd128(), 16'h0000);
        n_vec++;
        if (state !== 2'd1 || adc_valid !== 1'b0 || err_cnt !== (ERRCNT_ON ? c0 + ERR_W'(1) : '0)) begin
            n_bad++;
            $display("FAIL misalign: got st=%0d v=%b cnt=%0d exp st=1 v=0 cnt=%0d",
                     state, adc_valid, err_cnt, ERRCNT_ON ? c0 + ERR_W'(1) : '0);
        end
        for (int i = 0; i < 10; i++) beat(rnd128(), 16'h0000);
        n_vec++;
        if ({adc_a, adc_b, adc_valid, state, err_cnt} !== {e_a, e_b, e_v, e_state, e_cnt}) begin
            n_bad++;
            $display("FAIL misalign relock: got a=%h b=%h v=%b st=%0d cnt=%0d exp a=%h b=%h v=%b st=%0d cnt=%0d",
                     adc_a, adc_b, adc_valid, state, err_cnt, e_a, e_b, e_v, e_state, e_cnt);
        end
    endtask

    task automatic test_sync_loss();
        logic [ERR_W-1:0] c0;
        c0 = err_cnt;
        rx_sync = 1'b0;
        beat(rnd128(), 16'h0000);
        n_vec++;
        if (state !== 2'd0 || err_cnt !== c0) begin
            n_bad++;
            $display("FAIL sync_loss state: got st=%0d cnt=%0d exp st=0 cnt=%0d", state, err_cnt, c0);
        end
        beat(rnd128(), 16'h0000);
        n_vec++;
        if (adc_valid !== 1'b0 || state !== 2'd0 || err_cnt !== c0) begin
            n_bad++;
            $display("FAIL sync_loss valid: got v=%b st=%0d cnt=%0d exp v=0 st=0 cnt=%0d", adc_valid, state, err_cnt, c0);
        end
        rx_sync = 1'b1;
    endtask

    task automatic test_reset_mid_acq();
        b_ph = 0;
        for (int i = 0; i < 3; i++) beat(rnd128(), 16'h0000);
        n_vec++;
        if (state !== 2'd1) begin
            n_bad++;
            $display("FAIL reset_mid_acq precondition: got st=%0d exp 1", state);
        end
        #2 rst = 1'b1;
        #1;
        model_reset();
        n_vec++;
        if ({adc_a, adc_b, adc_valid, state, err_cnt} !== '0) begin
            n_bad++;
            $display("FAIL reset_mid_acq: got a=%h b=%h v=%b st=%0d cnt=%0d exp all zero", adc_a, adc_b, adc_valid, state, err_cnt);
        end
        @(posedge clk);
        #1 rst = 1'b0;
    endtask

    task automatic test_saturation();
        b_ph = 0;
        beat(rnd128(), 16'h0000);
        rx_start_of_multiframe = 4'b0100;
        for (int i = 0; i < 21; i++) step();
        n_vec++;
        if (state !== 2'd1 || err_cnt !== (ERRCNT_ON ? 4'd15 : 4'd0)) begin
            n_bad++;
            $display("FAIL saturation: got st=%0d cnt=%0d exp st=1 cnt=%0d", state, err_cnt, ERRCNT_ON ? 15 : 0);
        end
        clear_err = 1'b1;
        step();
        clear_err = 1'b0;
        n_vec++;
        if (err_cnt !== '0) begin
            n_bad++;
            $display("FAIL clear_vs_event: got cnt=%0d exp 0", err_cnt);
        end
        step();
        n_vec++;
        if (err_cnt !== e_cnt) begin
            n_bad++;
            $display("FAIL count_after_clear: got cnt=%0d exp %0d", err_cnt, e_cnt);
        end
        b_ph = 0;
    endtask

    task automatic test_random();
        for (int i = 0; i < 400; i++) begin
            rx_sync    = ($urandom_range(0, 99) >= 2);
            rx_aresetn = ($urandom_range(0, 99) >= 1);
            clear_err  = ($urandom_range(0, 99) < 3);
            rx_tdata   = rnd128();
            rx_tvalid  = 1'b1;
            rx_start_of_multiframe = (b_ph == 0) ? 4'b0001 : 4'b0000;
            if ($urandom_range(0, 99) < 4) rx_start_of_multiframe = 4'($urandom_range(0, 15));
            rx_frame_error = ($urandom_range(0, 99) < 5) ? 16'(1 << $urandom_range(0, 15)) : 16'h0000;
            b_ph = 1 - b_ph;
            step();
            n_vec++;
            if ({adc_a, adc_b, adc_valid, state, err_cnt} !== {e_a, e_b, e_v, e_state, e_cnt}) begin
                n_bad++;
                $display("FAIL random beat %0d: got a=%h b=%h v=%b st=%0d cnt=%0d exp a=%h b=%h v=%b st=%0d cnt=%0d",
                         i, adc_a, adc_b, adc_valid, state, err_cnt, e_a, e_b, e_v, e_state, e_cnt);
            end
        end
        rx_sync = 1'b1; rx_aresetn = 1'b1; clear_err = 1'b0;
    endtask

    initial begin
        test_reset();
        test_clean_lock();
        test_frame_error();
        test_misalign();
        test_sync_loss();
        test_reset_mid_acq();
        test_saturation();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
`default_nettype wire
